arbitro_balance: RTL

- Arbitrates two card-controller front-ends (cajero 0 and cajero 1) that share a single account-balance register and its add/subtract datapath.
- Grants one transaction at a time with round-robin priority and applies the card commission.
- Checks for insufficient funds and deposit overflow, then commits the new balance and reports the result to the granted requester.
- Sits between the per-terminal PIN/transaction controllers and the shared balance store.

---
 rtl/arbitro_balance.sv | 131 +++++++++++++
 1 files changed

// File: rtl/arbitro_balance.sv
// Round-robin arbiter for two card terminals sharing one balance register.
// Each transaction takes three cycles (IDLE -> EXEC -> RESP) and charges an optional fee.
module arbitro_balance #(
    parameter int unsigned      ANCHO           = 32,
    parameter int unsigned      COMISION        = 500,
    parameter logic [ANCHO-1:0] BALANCE_INICIAL = 'd50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             tipo_trans0,
    input  logic             tipo_trans1,
    input  logic [ANCHO-1:0] monto0,
    input  logic [ANCHO-1:0] monto1,
    input  logic             comision_en0,
    input  logic             comision_en1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done,
    output logic             done_id,
    output logic             fondos_insuficientes,
    output logic             desborde,
    output logic [ANCHO-1:0] balance,
    output logic             ocupado
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [ANCHO:0] FEE = (ANCHO+1)'(COMISION);

    state_t           state_q, state_d;
    logic [ANCHO-1:0] balance_q, balance_d;
    logic [ANCHO-1:0] monto_q, monto_d;
    logic             ptr_q, ptr_d;
    logic             winner_q, winner_d;
    logic             tipo_q, tipo_d;
    logic             com_q, com_d;
    logic             insuf_q, insuf_d;
    logic             desb_q, desb_d;

    logic [ANCHO:0]   fee, total, sum, bal_ext, monto_ext;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            balance_q <= BALANCE_INICIAL;
            ptr_q     <= 1'b0;
            winner_q  <= 1'b0;
            tipo_q    <= 1'b0;
            monto_q   <= '0;
            com_q     <= 1'b0;
            insuf_q   <= 1'b0;
            desb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            balance_q <= balance_d;
            ptr_q     <= ptr_d;
            winner_q  <= winner_d;
            tipo_q    <= tipo_d;
            monto_q   <= monto_d;
            com_q     <= com_d;
            insuf_q   <= insuf_d;
            desb_q    <= desb_d;
        end
    end

    // One extra bit exposes both the borrow of a withdrawal and the carry of a deposit.
    always_comb begin
        fee       = com_q ? FEE : '0;
        monto_ext = {1'b0, monto_q};
        bal_ext   = {1'b0, balance_q};
        total     = monto_ext + fee;
        sum       = bal_ext + (monto_ext - fee);
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        ptr_d     = ptr_q;
        winner_d  = winner_q;
        tipo_d    = tipo_q;
        monto_d   = monto_q;
        com_d     = com_q;
        insuf_d   = 1'b0;
        desb_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    winner_d = (req0 && req1) ? ptr_q : req1;
                    tipo_d   = winner_d ? tipo_trans1  : tipo_trans0;
                    monto_d  = winner_d ? monto1       : monto0;
                    com_d    = winner_d ? comision_en1 : comision_en0;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                if (tipo_q) begin
                    if (total > bal_ext) insuf_d   = 1'b1;
                    else                 balance_d = balance_q - total[ANCHO-1:0];
                end else if (monto_ext < fee) begin
                    insuf_d = 1'b1;
                end else if (sum[ANCHO]) begin
                    desb_d = 1'b1;
                end else begin
                    balance_d = sum[ANCHO-1:0];
                end
            end
            RESP: begin
                ptr_d   = ~winner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ocupado              = (state_q != IDLE);
        gnt0                 = ocupado && !winner_q;
        gnt1                 = ocupado &&  winner_q;
        done                 = (state_q == RESP);
        done_id              = done && winner_q;
        fondos_insuficientes = insuf_q;
        desborde             = desb_q;
        balance              = balance_q;
    end

endmodule
